// File: rtl/ascon_cipher_collector.sv
// Collects ASCON ciphertext words into a show-ahead FIFO and latches the final tag.
// Optional tag comparison is compiled in with `define ASCON_TAG_CHECK_EN.
module ascon_cipher_collector #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 128
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic                       cipher_valid_i,
    input  logic [DATA_W-1:0]          cipher_i,
    input  logic                       end_i,
    input  logic [TAG_W-1:0]           tag_i,
`ifdef ASCON_TAG_CHECK_EN
    input  logic [TAG_W-1:0]           expected_tag_i,
    output logic                       tag_ok_o,
    output logic                       tag_err_o,
`endif
    input  logic                       rd_ready_i,
    output logic                       rd_valid_o,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic [$clog2(DEPTH):0]     word_cnt_o,
    output logic                       tag_valid_o,
    output logic [TAG_W-1:0]           tag_o,
    output logic                       busy_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        r_state;
    logic              r_start_prev;
    logic              r_cv_prev;
    logic              r_end_prev;
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [CW-1:0]     r_word_cnt;
    logic              r_tag_valid;
    logic [TAG_W-1:0]  r_tag;
    logic              r_overflow;
    logic [DATA_W-1:0] r_mem [DEPTH];
`ifdef ASCON_TAG_CHECK_EN
    logic              r_tag_ok;
    logic              r_tag_err;
`endif

    logic w_start_rise;
    logic w_cv_rise;
    logic w_end_rise;
    logic w_armed;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_req;
    logic w_push;
    logic w_tag_evt;

    assign w_start_rise = start_i & ~r_start_prev;
    assign w_cv_rise    = cipher_valid_i & ~r_cv_prev;
    assign w_end_rise   = end_i & ~r_end_prev;
    assign w_armed      = (r_state == ST_ARMED);

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A start rise supersedes every capture event in the same cycle.
    assign w_pop      = ~w_empty & rd_ready_i & ~w_start_rise;
    assign w_push_req = w_armed & w_cv_rise & ~w_start_rise;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_tag_evt  = w_armed & w_end_rise & ~w_start_rise;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_start_prev <= 1'b0;
            r_cv_prev    <= 1'b0;
            r_end_prev   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_word_cnt   <= '0;
            r_tag_valid  <= 1'b0;
            r_tag        <= '0;
            r_overflow   <= 1'b0;
`ifdef ASCON_TAG_CHECK_EN
            r_tag_ok     <= 1'b0;
            r_tag_err    <= 1'b0;
`endif
        end else begin
            r_start_prev <= start_i;
            r_cv_prev    <= cipher_valid_i;
            r_end_prev   <= end_i;
            if (w_start_rise) begin
                r_state     <= ST_ARMED;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_word_cnt  <= '0;
                r_tag_valid <= 1'b0;
                r_tag       <= '0;
                r_overflow  <= 1'b0;
`ifdef ASCON_TAG_CHECK_EN
                r_tag_ok    <= 1'b0;
                r_tag_err   <= 1'b0;
`endif
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_push_req && !w_push) begin
                    r_overflow <= 1'b1;
                end
                // Counts every strobe, including dropped ones, up to all-ones.
                if (w_push_req && (r_word_cnt != {CW{1'b1}})) begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
                if (w_tag_evt) begin
                    r_state     <= ST_DONE;
                    r_tag       <= tag_i;
                    r_tag_valid <= 1'b1;
`ifdef ASCON_TAG_CHECK_EN
                    r_tag_ok    <= (tag_i == expected_tag_i);
                    r_tag_err   <= (tag_i != expected_tag_i);
`endif
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= cipher_i;
        end
    end

    assign rd_valid_o  = ~w_empty;
    assign rd_data_o   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign word_cnt_o  = r_word_cnt;
    assign tag_valid_o = r_tag_valid;
    assign tag_o       = r_tag;
    assign busy_o      = w_armed;
    assign overflow_o  = r_overflow;
`ifdef ASCON_TAG_CHECK_EN
    assign tag_ok_o    = r_tag_ok;
    assign tag_err_o   = r_tag_err;
`endif

endmodule

// File: tb/tb_ascon_cipher_collector.sv
// Directed bench for ascon_cipher_collector (DEPTH=8); tag-check cases under ASCON_TAG_CHECK_EN.
module tb_ascon_cipher_collector;

    logic         clk;
    logic         rst;
    logic         start;
    logic         cv;
    logic [63:0]  cipher;
    logic         end_s;
    logic [127:0] tag_in;
    logic         rd_ready;
    logic         rd_valid;
    logic [63:0]  rd_data;
    logic [3:0]   word_cnt;
    logic         tag_valid;
    logic [127:0] tag_out;
    logic         busy;
    logic         overflow;
`ifdef ASCON_TAG_CHECK_EN
    logic [127:0] exp_tag;
    logic         tag_ok;
    logic         tag_err;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [127:0] TAG_A5 = {16{8'hA5}};
    localparam logic [127:0] TAG_5  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    ascon_cipher_collector #(.DEPTH(8), .DATA_W(64), .TAG_W(128)) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .start_i        (start),
        .cipher_valid_i (cv),
        .cipher_i       (cipher),
        .end_i          (end_s),
        .tag_i          (tag_in),
`ifdef ASCON_TAG_CHECK_EN
        .expected_tag_i (exp_tag),
        .tag_ok_o       (tag_ok),
        .tag_err_o      (tag_err),
`endif
        .rd_ready_i     (rd_ready),
        .rd_valid_o     (rd_valid),
        .rd_data_o      (rd_data),
        .word_cnt_o     (word_cnt),
        .tag_valid_o    (tag_valid),
        .tag_o          (tag_out),
        .busy_o         (busy),
        .overflow_o     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, obs, exp);
        end else begin
            $display("[TB] ok   %s: %0h", name, obs);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
    endtask

    task automatic pulse_word(input logic [63:0] d, input int width);
        cipher = d;
        cv = 1'b1;
        tick(width);
        cv = 1'b0;
        tick(1);
    endtask

    task automatic do_end(input logic [127:0] t);
        tag_in = t;
        end_s = 1'b1;
        tick(1);
        end_s = 1'b0;
        tick(1);
    endtask

    task automatic pop_expect(input string name, input logic [63:0] d);
        check({name, "_valid"}, {127'd0, rd_valid}, 128'd1);
        check({name, "_data"}, {64'd0, rd_data}, {64'd0, d});
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cv = 1'b0; cipher = '0; end_s = 1'b0;
        tag_in = '0; rd_ready = 1'b0;
`ifdef ASCON_TAG_CHECK_EN
        exp_tag = '0;
`endif
        tick(2);
        check("rst_rd_valid", {127'd0, rd_valid}, 128'd0);
        check("rst_word_cnt", {124'd0, word_cnt}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_tag", tag_out, 128'd0);
        rst = 1'b0;
        tick(1);

        // Reset in the middle of a message
        do_start();
        check("t1_busy", {127'd0, busy}, 128'd1);
        pulse_word(64'hAAAA_0000_0000_0001, 1);
        pulse_word(64'hAAAA_0000_0000_0002, 1);
        check("t1_cnt_pre", {124'd0, word_cnt}, 128'd2);
        rst = 1'b1;
        #1;
        check("t1_rd_valid", {127'd0, rd_valid}, 128'd0);
        check("t1_word_cnt", {124'd0, word_cnt}, 128'd0);
        check("t1_tag_valid", {127'd0, tag_valid}, 128'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Nominal message with 2-cycle strobes
        do_start();
        pulse_word({4{16'h1111}}, 2);
        check("t2_first_visible", {64'd0, rd_data}, {64'd0, {4{16'h1111}}});
        pulse_word({4{16'h2222}}, 2);
        pulse_word({4{16'h3333}}, 2);
        pulse_word({4{16'h4444}}, 2);
        do_end(TAG_A5);
        check("t2_word_cnt", {124'd0, word_cnt}, 128'd4);
        check("t2_tag_valid", {127'd0, tag_valid}, 128'd1);
        check("t2_tag", tag_out, TAG_A5);
        check("t2_busy_done", {127'd0, busy}, 128'd0);
        pop_expect("t2_w0", {4{16'h1111}});
        pop_expect("t2_w1", {4{16'h2222}});
        pop_expect("t2_w2", {4{16'h3333}});
        pop_expect("t2_w3", {4{16'h4444}});
        check("t2_empty", {127'd0, rd_valid}, 128'd0);
        rd_ready = 1'b1;
        tick(2);
        rd_ready = 1'b0;
        check("t2_empty_rd", {127'd0, rd_valid}, 128'd0);
        check("t2_cnt_kept", {124'd0, word_cnt}, 128'd4);

        // Start clears tag
        do_start();
        check("t2_restart_tag_valid", {127'd0, tag_valid}, 128'd0);
        check("t2_restart_tag", tag_out, 128'd0);

        // Overflow with no reads
        for (int i = 1; i <= 9; i++) pulse_word({32'hC0DE_0000, i[31:0]}, 1);
        check("t3_overflow", {127'd0, overflow}, 128'd1);
        check("t3_word_cnt", {124'd0, word_cnt}, 128'd9);
        for (int i = 1; i <= 8; i++) pop_expect($sformatf("t3_w%0d", i), {32'hC0DE_0000, i[31:0]});
        check("t3_drained", {127'd0, rd_valid}, 128'd0);
        do_start();
        check("t3_ovf_cleared", {127'd0, overflow}, 128'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 1; i <= 8; i++) pulse_word({32'hF00D_0000, i[31:0]}, 1);
        check("t4_cnt8", {124'd0, word_cnt}, 128'd8);
        cipher = {32'hF00D_0000, 32'd9};
        cv = 1'b1;
        rd_ready = 1'b1;
        tick(1);
        cv = 1'b0;
        rd_ready = 1'b0;
        tick(1);
        check("t4_overflow", {127'd0, overflow}, 128'd0);
        check("t4_word_cnt", {124'd0, word_cnt}, 128'd9);
        for (int i = 2; i <= 9; i++) pop_expect($sformatf("t4_w%0d", i), {32'hF00D_0000, i[31:0]});
        check("t4_drained", {127'd0, rd_valid}, 128'd0);

        // Last word and end on the same edge
        do_start();
        pulse_word(64'h5555_0000_0000_0001, 1);
        cipher = 64'hDEAD_BEEF_0000_0001;
        tag_in = TAG_5;
        cv = 1'b1;
        end_s = 1'b1;
        tick(1);
        cv = 1'b0;
        end_s = 1'b0;
        check("t5_tag_valid", {127'd0, tag_valid}, 128'd1);
        check("t5_word_cnt", {124'd0, word_cnt}, 128'd2);
        tick(1);
        pulse_word(64'h0BAD_0BAD_0BAD_0BAD, 1);
        do_end(TAG_A5);
        check("t5_cnt_done", {124'd0, word_cnt}, 128'd2);
        check("t5_tag_kept", tag_out, TAG_5);
        pop_expect("t5_w0", 64'h5555_0000_0000_0001);
        pop_expect("t5_w1", 64'hDEAD_BEEF_0000_0001);
        check("t5_drained", {127'd0, rd_valid}, 128'd0);

        // Mid-message restart flushes
        do_start();
        pulse_word(64'h7777_0000_0000_0001, 1);
        pulse_word(64'h7777_0000_0000_0002, 1);
        do_start();
        check("t6_flush_valid", {127'd0, rd_valid}, 128'd0);
        check("t6_flush_cnt", {124'd0, word_cnt}, 128'd0);
        check("t6_busy", {127'd0, busy}, 128'd1);

`ifdef ASCON_TAG_CHECK_EN
        exp_tag = TAG_A5;
        pulse_word(64'h1, 1);
        do_end(TAG_A5);
        check("t6_tag_ok", {127'd0, tag_ok}, 128'd1);
        check("t6_tag_err0", {127'd0, tag_err}, 128'd0);
        do_start();
        check("t6_ok_clr", {127'd0, tag_ok}, 128'd0);
        exp_tag = TAG_A5 ^ 128'd1;
        do_end(TAG_A5);
        check("t6_tag_err", {127'd0, tag_err}, 128'd1);
        check("t6_tag_ok0", {127'd0, tag_ok}, 128'd0);
        do_start();
        check("t6_err_clr", {127'd0, tag_err}, 128'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
